// File: rtl/uart_fifo_core_if.sv
// Host-side strobe/data bus of uart_fifo_core: write/read strobes, TX/RX bytes and FIFO ready flags.
interface uart_fifo_core_if;
  logic       CSN, WEN, OEN;
  logic [7:0] DATA_IN, DATA_OUT;
  logic       TXRDY, RXRDY;

  modport master (output CSN, WEN, OEN, DATA_IN, input DATA_OUT, TXRDY, RXRDY);
  modport slave  (input CSN, WEN, OEN, DATA_IN, output DATA_OUT, TXRDY, RXRDY);
endinterface

// File: rtl/uart_fifo_core.sv
// Full-duplex UART with TX/RX FIFOs, runtime frame format (5-8 bits, parity, 1/2 stop),
// shared 16x baud tick and sticky error flags.
module uart_fifo_core #(
  parameter int FIFO_DEPTH_TX = 16,
  parameter int FIFO_DEPTH_RX = 16,
  parameter int RX_THRESH     = 8
) (
  input  logic                             CLK,
  input  logic                             RESET_N,
  uart_fifo_core_if.slave                  bus,
  input  logic [12:0]                      BAUD_VAL,
  input  logic [1:0]                       DATA_LEN,
  input  logic                             PARITY_EN,
  input  logic                             ODD_N_EVEN,
  input  logic                             STOP2,
  input  logic                             CLR_ERR,
  input  logic                             RX,
  output logic                             TX,
  output logic                             TX_EMPTY,
  output logic                             RX_THR,
  output logic [$clog2(FIFO_DEPTH_RX):0]   RX_LEVEL,
  output logic                             PARITY_ERR,
  output logic                             FRAMING_ERR,
  output logic                             OVERFLOW
);
  localparam int TAW = $clog2(FIFO_DEPTH_TX);
  localparam int RAW = $clog2(FIFO_DEPTH_RX);

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_START, S_DATA, S_PAR, S_STOP} state_e;

  // Baud generator
  logic [12:0] baud_q, baud_d;
  logic        tick;
  assign tick   = (baud_q == '0);
  assign baud_d = tick ? BAUD_VAL : baud_q - 13'd1;
  always_ff @(posedge CLK)
    if (!RESET_N) baud_q <= '0;
    else          baud_q <= baud_d;

  // TX FIFO
  logic [7:0]   txm_q [FIFO_DEPTH_TX];
  logic [TAW-1:0] txw_q, txr_q;
  logic [TAW:0] txc_q;
  logic         tx_full, tx_push, tx_pop;
  state_e       txs_q;

  assign tx_full = (txc_q == (TAW+1)'(FIFO_DEPTH_TX));
  assign tx_push = !bus.CSN && !bus.WEN && !tx_full;
  assign tx_pop  = (txs_q == S_IDLE) && (txc_q != '0);

  always_ff @(posedge CLK)
    if (tx_push) txm_q[txw_q] <= bus.DATA_IN;

  always_ff @(posedge CLK) begin
    if (!RESET_N) begin
      txw_q <= '0; txr_q <= '0; txc_q <= '0;
    end else begin
      if (tx_push) txw_q <= txw_q + 1'b1;
      if (tx_pop)  txr_q <= txr_q + 1'b1;
      case ({tx_push, tx_pop})
        2'b10:   txc_q <= txc_q + 1'b1;
        2'b01:   txc_q <= txc_q - 1'b1;
        default: ;
      endcase
    end
  end

  // Transmitter; the frame format is captured at load so config edits hit the next frame
  logic [7:0] txsh_q, tx_byte;
  logic [4:0] txt_q, txt_end;
  logic [2:0] txb_q, tx_last;
  logic [1:0] txlen_q;
  logic       txpar_q, txpe_q, txst2_q, tx_q;

  assign tx_byte = txm_q[txr_q] & (8'hFF >> (2'd3 - DATA_LEN));
  assign tx_last = 3'd4 + {1'b0, txlen_q};
  assign txt_end = (txs_q == S_STOP && txst2_q) ? 5'd31 : 5'd15;

  always_ff @(posedge CLK) begin
    if (!RESET_N) begin
      txs_q <= S_IDLE; tx_q <= 1'b1; txt_q <= '0; txb_q <= '0; txsh_q <= '0;
      txpar_q <= 1'b0; txlen_q <= '0; txpe_q <= 1'b0; txst2_q <= 1'b0;
    end else begin
      case (txs_q)
        S_IDLE: if (tx_pop) begin
          txs_q   <= S_LOAD;
          txsh_q  <= tx_byte;
          txpar_q <= ^tx_byte ^ ODD_N_EVEN;
          txlen_q <= DATA_LEN;
          txpe_q  <= PARITY_EN;
          txst2_q <= STOP2;
        end
        S_LOAD: if (tick) begin
          txs_q <= S_START; tx_q <= 1'b0; txt_q <= '0;
        end
        default: if (tick) begin
          if (txt_q != txt_end) txt_q <= txt_q + 5'd1;
          else begin
            txt_q <= '0;
            case (txs_q)
              S_START: begin
                txs_q <= S_DATA; txb_q <= '0; tx_q <= txsh_q[0]; txsh_q <= txsh_q >> 1;
              end
              S_DATA:
                if (txb_q != tx_last) begin
                  txb_q <= txb_q + 3'd1; tx_q <= txsh_q[0]; txsh_q <= txsh_q >> 1;
                end else if (txpe_q) begin
                  txs_q <= S_PAR; tx_q <= txpar_q;
                end else begin
                  txs_q <= S_STOP; tx_q <= 1'b1;
                end
              S_PAR:   begin txs_q <= S_STOP; tx_q <= 1'b1; end
              default: begin txs_q <= S_IDLE; tx_q <= 1'b1; end
            endcase
          end
        end
      endcase
    end
  end

  assign TX          = tx_q;
  assign TX_EMPTY    = (txc_q == '0) && (txs_q == S_IDLE);
  assign bus.TXRDY   = !tx_full;

  // Receiver: all samples come from the synchronised line rs2_q
  logic       rs1_q, rs2_q, rprev_q, rxpb_q;
  logic [3:0] rxt_q;
  logic [2:0] rxb_q, rx_last;
  logic [7:0] rxsh_q, rx_byte;
  logic       rx_mid, rx_stop;
  state_e     rxs_q;

  assign rx_last = 3'd4 + {1'b0, DATA_LEN};
  assign rx_mid  = tick && (rxt_q == 4'd7);
  assign rx_stop = (rxs_q == S_STOP) && rx_mid;
  assign rx_byte = rxsh_q >> (2'd3 - DATA_LEN);

  always_ff @(posedge CLK) begin
    if (!RESET_N) begin
      rs1_q <= 1'b1; rs2_q <= 1'b1; rprev_q <= 1'b1;
      rxs_q <= S_IDLE; rxt_q <= '0; rxb_q <= '0; rxsh_q <= '0; rxpb_q <= 1'b0;
    end else begin
      rs1_q <= RX; rs2_q <= rs1_q; rprev_q <= rs2_q;
      case (rxs_q)
        S_IDLE: if (rprev_q && !rs2_q) begin rxs_q <= S_START; rxt_q <= '0; end
        S_START, S_DATA, S_PAR, S_STOP: if (tick) begin
          rxt_q <= rxt_q + 4'd1;
          if (rx_mid) begin
            if (rxs_q == S_START && rs2_q) rxs_q <= S_IDLE;
            if (rxs_q == S_DATA)           rxsh_q <= {rs2_q, rxsh_q[7:1]};
            if (rxs_q == S_PAR)            rxpb_q <= rs2_q;
            if (rxs_q == S_STOP)           rxs_q <= S_IDLE;
          end
          if (rxt_q == 4'd15) begin
            if (rxs_q == S_START) begin
              rxs_q <= S_DATA; rxb_q <= '0;
            end else if (rxs_q == S_DATA) begin
              if (rxb_q != rx_last) rxb_q <= rxb_q + 3'd1;
              else                  rxs_q <= PARITY_EN ? S_PAR : S_STOP;
            end else if (rxs_q == S_PAR) begin
              rxs_q <= S_STOP;
            end
          end
        end
        default: rxs_q <= S_IDLE;
      endcase
    end
  end

  // RX FIFO, first-word-fall-through
  logic [7:0]     rxm_q [FIFO_DEPTH_RX];
  logic [RAW-1:0] rxw_q, rxr_q;
  logic [RAW:0]   rxc_q;
  logic           rx_full, rx_push, rx_pop;

  assign rx_full = (rxc_q == (RAW+1)'(FIFO_DEPTH_RX));
  assign rx_push = rx_stop && !rx_full;
  assign rx_pop  = !bus.CSN && !bus.OEN && (rxc_q != '0);

  always_ff @(posedge CLK)
    if (rx_push) rxm_q[rxw_q] <= rx_byte;

  always_ff @(posedge CLK) begin
    if (!RESET_N) begin
      rxw_q <= '0; rxr_q <= '0; rxc_q <= '0;
    end else begin
      if (rx_push) rxw_q <= rxw_q + 1'b1;
      if (rx_pop)  rxr_q <= rxr_q + 1'b1;
      case ({rx_push, rx_pop})
        2'b10:   rxc_q <= rxc_q + 1'b1;
        2'b01:   rxc_q <= rxc_q - 1'b1;
        default: ;
      endcase
    end
  end

  assign bus.RXRDY    = (rxc_q != '0);
  assign bus.DATA_OUT = (rxc_q != '0) ? rxm_q[rxr_q] : 8'h00;
  assign RX_LEVEL     = rxc_q;
  assign RX_THR       = (rxc_q >= (RAW+1)'(RX_THRESH));

  // Sticky errors; a set in the same cycle as CLR_ERR wins
  logic pe_q, fe_q, ov_q;
  always_ff @(posedge CLK) begin
    if (!RESET_N) begin
      pe_q <= 1'b0; fe_q <= 1'b0; ov_q <= 1'b0;
    end else begin
      pe_q <= (rx_stop && PARITY_EN && (rxpb_q != (^rx_byte ^ ODD_N_EVEN))) || (pe_q && !CLR_ERR);
      fe_q <= (rx_stop && !rs2_q) || (fe_q && !CLR_ERR);
      ov_q <= (rx_stop && rx_full) || (ov_q && !CLR_ERR);
    end
  end

  assign PARITY_ERR  = pe_q;
  assign FRAMING_ERR = fe_q;
  assign OVERFLOW    = ov_q;
endmodule

// File: tb/tb_uart_fifo_core.sv
// Scoreboard bench for uart_fifo_core: serial frames driven or looped back, RX FIFO contents
// compared against a queue of expected bytes.
module tb_uart_fifo_core;
  logic        CLK = 1'b0, RESET_N = 1'b0;
  logic [12:0] BAUD_VAL;
  logic [1:0]  DATA_LEN;
  logic        PARITY_EN, ODD_N_EVEN, STOP2, CLR_ERR;
  logic        rx_drv, loop_en, rx_pin, TX, TX_EMPTY, RX_THR;
  logic        PARITY_ERR, FRAMING_ERR, OVERFLOW;
  logic [4:0]  RX_LEVEL;

  always #5 CLK = ~CLK;

  uart_fifo_core_if bus();
  assign rx_pin = loop_en ? TX : rx_drv;

  uart_fifo_core #(.FIFO_DEPTH_TX(16), .FIFO_DEPTH_RX(16), .RX_THRESH(8)) dut (
    .CLK(CLK), .RESET_N(RESET_N), .bus(bus), .BAUD_VAL(BAUD_VAL), .DATA_LEN(DATA_LEN),
    .PARITY_EN(PARITY_EN), .ODD_N_EVEN(ODD_N_EVEN), .STOP2(STOP2), .CLR_ERR(CLR_ERR),
    .RX(rx_pin), .TX(TX), .TX_EMPTY(TX_EMPTY), .RX_THR(RX_THR), .RX_LEVEL(RX_LEVEL),
    .PARITY_ERR(PARITY_ERR), .FRAMING_ERR(FRAMING_ERR), .OVERFLOW(OVERFLOW));

  int         n_cmp = 0, n_bad = 0;
  logic [7:0] sb_q[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h @%0t", tag, obs, exp, $time);
    end
  endtask

  // All tasks start and end 1 time unit after a rising edge.
  task automatic step(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  task automatic wr(input logic [7:0] d);
    bus.CSN = 1'b0; bus.WEN = 1'b0; bus.DATA_IN = d;
    step(1);
    bus.CSN = 1'b1; bus.WEN = 1'b1;
  endtask

  task automatic rd_chk(input string tag);
    logic [7:0] exp;
    exp = (sb_q.size() > 0) ? sb_q.pop_front() : 8'h00;
    chk(tag, bus.DATA_OUT, exp);
    bus.CSN = 1'b0; bus.OEN = 1'b0;
    step(1);
    bus.CSN = 1'b1; bus.OEN = 1'b1;
  endtask

  task automatic drain(input string tag);
    int k;
    while (sb_q.size() > 0) begin
      k = 0;
      while (!bus.RXRDY && k < 2000) begin step(1); k++; end
      if (!bus.RXRDY) begin
        chk({tag, "_timeout"}, bus.RXRDY, 1);
        sb_q.delete();
      end else rd_chk(tag);
    end
  endtask

  task automatic wait_tx_low(input string tag);
    int k = 0;
    while (TX && k < 200) begin step(1); k++; end
    chk(tag, TX, 0);
  endtask

  task automatic wait_level(input string tag, input int v);
    int k = 0;
    while (RX_LEVEL != v[4:0] && k < 4000) begin step(1); k++; end
    chk(tag, RX_LEVEL, v);
  endtask

  // Bench-driven frame at BAUD_VAL=0 (16 clocks per bit). The DUT samples the stop bit
  // on edge 27+16*(data+parity bits) counted from the edge this task starts after.
  task automatic send_serial(input logic [7:0] d, input int nd, input bit pen,
                             input bit pbit, input bit stopb);
    rx_drv = 1'b0; step(16);
    for (int i = 0; i < nd; i++) begin rx_drv = d[i]; step(16); end
    if (pen) begin rx_drv = pbit; step(16); end
    rx_drv = stopb; step(16);
    rx_drv = 1'b1; step(16);
  endtask

  task automatic clr_pulse();
    CLR_ERR = 1'b1; step(1); CLR_ERR = 1'b0;
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_tx"}, TX, 1);
    chk({tag, "_dout"}, bus.DATA_OUT, 0);
    chk({tag, "_txrdy"}, bus.TXRDY, 1);
    chk({tag, "_txempty"}, TX_EMPTY, 1);
    chk({tag, "_rxrdy"}, bus.RXRDY, 0);
    chk({tag, "_rxthr"}, RX_THR, 0);
    chk({tag, "_level"}, RX_LEVEL, 0);
    chk({tag, "_errs"}, {PARITY_ERR, FRAMING_ERR, OVERFLOW}, 0);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] d;
    int n;
    bus.CSN = 1'b1; bus.WEN = 1'b1; bus.OEN = 1'b1; bus.DATA_IN = 8'h00;
    BAUD_VAL = 13'd3; DATA_LEN = 2'd3; PARITY_EN = 1'b0; ODD_N_EVEN = 1'b0; STOP2 = 1'b0;
    CLR_ERR = 1'b0; rx_drv = 1'b1; loop_en = 1'b1;
    step(3);
    RESET_N = 1'b1;
    step(2);
    chk_reset("rst");

    // 0x55, 8N1, BAUD_VAL=3: 64 clocks per bit, looped back into RX
    d = 8'h55;
    wr(d);
    sb_q.push_back(d);
    chk("t1_txempty_fall", TX_EMPTY, 0);
    wait_tx_low("t1_start_seen");
    step(32);
    chk("t1_start_bit", TX, 0);
    for (int i = 0; i < 8; i++) begin
      step(64);
      chk("t1_data_bit", TX, d[i]);
    end
    step(64);
    chk("t1_stop_bit", TX, 1);
    n = 32 + 64 * 9;
    while (!TX_EMPTY && n < 2000) begin step(1); n++; end
    chk("t1_frame_len", n, 640);
    drain("t1_rx");
    chk("t1_errs", {PARITY_ERR, FRAMING_ERR, OVERFLOW}, 0);

    // 18 back-to-back writes: one goes straight to the shifter, 16 fill the FIFO, last dropped
    BAUD_VAL = 13'd0;
    step(8);
    for (int i = 0; i < 18; i++) begin
      wr(8'(i));
      if (i < 17) sb_q.push_back(8'(i));
      if (i == 15) chk("t2_txrdy_hi", bus.TXRDY, 1);
      if (i == 16) chk("t2_txrdy_lo", bus.TXRDY, 0);
    end
    wait_level("t2_lvl7", 7);
    chk("t2_thr_below", RX_THR, 0);
    wait_level("t2_lvl8", 8);
    chk("t2_thr_at", RX_THR, 1);
    drain("t2_rx");
    n = 0;
    while (!TX_EMPTY && n < 1000) begin step(1); n++; end
    chk("t2_txempty", TX_EMPTY, 1);
    step(200);
    chk("t2_no_extra", bus.RXRDY, 0);
    chk("t2_ovf", OVERFLOW, 0);

    // 7E2, 0x41 with the parity bit inverted
    loop_en = 1'b0; DATA_LEN = 2'd2; PARITY_EN = 1'b1; ODD_N_EVEN = 1'b0; STOP2 = 1'b1;
    step(4);
    d = 8'h41;
    send_serial(d, 7, 1'b1, ~(^d), 1'b1);
    sb_q.push_back(d);
    chk("t3_perr_set", PARITY_ERR, 1);
    chk("t3_ferr", FRAMING_ERR, 0);
    drain("t3_rx");
    clr_pulse();
    chk("t3_perr_clr", PARITY_ERR, 0);
    fork
      send_serial(d, 7, 1'b1, ~(^d), 1'b1);
      begin step(26 + 16 * 8); clr_pulse(); end
    join
    sb_q.push_back(d);
    chk("t3_set_wins", PARITY_ERR, 1);
    drain("t3_rx2");
    clr_pulse();
    ODD_N_EVEN = 1'b1;
    d = 8'h15;
    send_serial(d, 7, 1'b1, ~(^d), 1'b1);
    sb_q.push_back(d);
    chk("t3_odd_ok", PARITY_ERR, 0);
    drain("t3_rx3");

    // Stop bit forced low, then an idle-line glitch
    DATA_LEN = 2'd3; PARITY_EN = 1'b0; ODD_N_EVEN = 1'b0; STOP2 = 1'b0;
    step(4);
    d = 8'hC3;
    send_serial(d, 8, 1'b0, 1'b0, 1'b0);
    sb_q.push_back(d);
    chk("t4_ferr", FRAMING_ERR, 1);
    chk("t4_level", RX_LEVEL, 1);
    drain("t4_rx");
    clr_pulse();
    chk("t4_ferr_clr", FRAMING_ERR, 0);
    rx_drv = 1'b0; step(4); rx_drv = 1'b1;
    step(60);
    chk("t4_glitch_level", RX_LEVEL, 0);
    chk("t4_glitch_ferr", FRAMING_ERR, 0);

    // Fill RX FIFO, overflow, then a pop coinciding with a push
    for (int i = 0; i < 16; i++) begin
      send_serial(8'(8'h80 + i), 8, 1'b0, 1'b0, 1'b1);
      sb_q.push_back(8'(8'h80 + i));
    end
    chk("t5_full_level", RX_LEVEL, 16);
    chk("t5_ovf_pre", OVERFLOW, 0);
    send_serial(8'hEE, 8, 1'b0, 1'b0, 1'b1);
    chk("t5_ovf_set", OVERFLOW, 1);
    chk("t5_ovf_level", RX_LEVEL, 16);
    rd_chk("t5_rd");
    rd_chk("t5_rd");
    chk("t5_level14", RX_LEVEL, 14);
    sb_q.push_back(8'h5A);
    fork
      send_serial(8'h5A, 8, 1'b0, 1'b0, 1'b1);
      begin step(26 + 16 * 8); rd_chk("t5_same_cycle"); end
    join
    chk("t5_level_same", RX_LEVEL, 14);
    drain("t5_drain");
    chk("t5_ovf_sticky", OVERFLOW, 1);

    // Reset mid-frame, then a clean frame
    loop_en = 1'b1;
    step(4);
    wr(8'h3C);
    wr(8'h3D);
    wait_tx_low("t6_start_seen");
    step(50);
    RESET_N = 1'b0;
    step(1);
    RESET_N = 1'b1;
    chk_reset("t6_rst");
    sb_q.delete();
    step(2);
    wr(8'hA5);
    sb_q.push_back(8'hA5);
    drain("t6_rx");
    chk("t6_errs", {PARITY_ERR, FRAMING_ERR, OVERFLOW}, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
